// File: rtl/seq_det_rr_sched_pkg.sv
// rtl/seq_det_rr_sched_pkg.sv - shared encodings and step function for the time-shared 111 detector
package seq_det_rr_sched_pkg;

    typedef logic [1:0] ctx_t;

    // Run-length context encodings; 2'b10 is unused and recovers to S0.
    localparam ctx_t S0 = 2'b00;
    localparam ctx_t S1 = 2'b01;
    localparam ctx_t S2 = 2'b11;

    typedef struct packed {
        ctx_t nxt;
        logic hit;
    } step_t;

    // One step of the overlapping "111" Mealy machine; hit uses the pre-update context.
    function automatic step_t fsm_step(input ctx_t ctx, input logic din);
        step_t r;
        r.hit = 1'b0;
        r.nxt = S0;
        case (ctx)
            S0: r.nxt = din ? S1 : S0;
            S1: r.nxt = din ? S2 : S0;
            S2: begin
                r.nxt = din ? S2 : S0;
                r.hit = din;
            end
            default: r.nxt = S0;
        endcase
        return r;
    endfunction

    // All-ones value of a w-bit counter, the saturation point.
    function automatic logic [31:0] cnt_sat(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/seq_det_rr_sched_if.sv
// rtl/seq_det_rr_sched_if.sv - request and result handshake bundle
interface seq_det_rr_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_bit;
    logic [NUM_CH-1:0] req_ready;
    logic              det_valid;
    logic [CH_W-1:0]   det_ch;
    logic              det_hit;

    modport master (
        output req_valid, req_bit,
        input  req_ready, det_valid, det_ch, det_hit
    );

    modport slave (
        input  req_valid, req_bit,
        output req_ready, det_valid, det_ch, det_hit
    );
endinterface

// File: rtl/seq_det_rr_sched_rr_arbiter.sv
// rtl/seq_det_rr_sched_rr_arbiter.sv - round-robin arbiter starting its search at the pointer
module seq_det_rr_sched_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/seq_det_rr_sched.sv
// rtl/seq_det_rr_sched.sv - round-robin time-shared overlapping 111 detector with per-channel hit counters
module seq_det_rr_sched
    import seq_det_rr_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_det_rr_sched_if.slave   bus,
    input  logic [NUM_CH-1:0]   chan_flush,
    input  logic                clr_cnt,
    input  logic [CH_W-1:0]     cnt_sel,
    output logic [CNT_W-1:0]    cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    ctx_t              ctx [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CH_W-1:0]   ptr;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   gidx;
    logic              any;
    step_t             st;

    seq_det_rr_sched_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign bus.req_ready = grant;

    // Run the granted channel's bit through the shared detector engine.
    always_comb begin
        st = fsm_step(ctx[gidx], bus.req_bit[gidx]);
    end

    // Per-channel contexts: flush beats the transfer update for the same channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= S0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chan_flush[i])
                    ctx[i] <= S0;
                else if (any && gidx == CH_W'(i))
                    ctx[i] <= st.nxt;
            end
        end
    end

    // Saturating hit counters; a global clear beats a coincident hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (any && st.hit && cnt[gidx] != CNT_MAX) begin
            cnt[gidx] <= cnt[gidx] + 1'b1;
        end
    end

    // Priority pointer moves just past the winner; it holds when nobody requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (any)
            ptr <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
    end

    // Registered result of the bit accepted in the previous cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.det_valid <= 1'b0;
            bus.det_ch    <= '0;
            bus.det_hit   <= 1'b0;
        end else begin
            bus.det_valid <= any;
            bus.det_hit   <= any & st.hit;
            if (any)
                bus.det_ch <= gidx;
        end
    end

    // Counter readout; out-of-range selects read as zero.
    always_comb begin
        cnt_out = '0;
        if (int'(cnt_sel) < NUM_CH)
            cnt_out = cnt[cnt_sel];
    end

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// tb/tb_seq_det_rr_sched.sv - table-driven scoreboard bench for seq_det_rr_sched
module tb_seq_det_rr_sched;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 2;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] flush;
        logic       clr;
        logic [3:0] ready;
        logic       hit;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic       hit;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [3:0]       chan_flush;
    logic             clr_cnt;
    logic [CH_W-1:0]  cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    seq_det_rr_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    seq_det_rr_sched #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .chan_flush (chan_flush),
        .clr_cnt    (clr_cnt),
        .cnt_sel    (cnt_sel),
        .cnt_out    (cnt_out)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] b, input logic [3:0] f,
                                input logic c, input logic [3:0] r, input logic h);
        vec_t x;
        x.valid = v; x.bits = b; x.flush = f; x.clr = c; x.ready = r; x.hit = h;
        return x;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_bit   = v.bits;
        chan_flush    = v.flush;
        clr_cnt       = v.clr;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(v.ready));
        if (v.ready != 4'd0) begin
            e.ch = 2'd0;
            for (int i = 0; i < 4; i++) if (v.ready[i]) e.ch = 2'(i);
            e.hit = v.hit;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("det_valid", 32'(bus.det_valid), 32'(v.ready != 4'd0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("det_ch", 32'(bus.det_ch), 32'(e.ch));
            chk("det_hit", 32'(bus.det_hit), 32'(e.hit));
        end else begin
            chk("det_hit_idle", 32'(bus.det_hit), 32'd0);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_cnt(input int ch, input int exp);
        cnt_sel = CH_W'(ch);
        #1;
        chk($sformatf("cnt_out[%0d]", ch), 32'(cnt_out), 32'(exp));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_bit   = 4'b0000;
        chan_flush    = 4'b0000;
        clr_cnt       = 1'b0;
        sb.delete();
        #1;
        chk("reset_det_valid", 32'(bus.det_valid), 32'd0);
        chk("reset_det_hit", 32'(bus.det_hit), 32'd0);
        chk("reset_det_ch", 32'(bus.det_ch), 32'd0);
        chk("reset_ready", 32'(bus.req_ready), 32'b0001);
        for (int i = 0; i < NUM_CH; i++) check_cnt(i, 0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_bit   = '0;
        chan_flush    = '0;
        clr_cnt       = 1'b0;
        cnt_sel       = '0;
        reset_dut();

        // Single channel stream 1,1,1,1,0,1,1,1
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b1));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0, 1'b0, 4'b0000, 1'b0));
        run_tbl();
        check_cnt(0, 3);

        // Fairness with every channel requesting
        reset_dut();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                tbl.push_back(mk(4'b1111, 4'b0000, 4'b0, 1'b0, 4'(1 << c), 1'b0));
        run_tbl();

        // Sparse requests: move pointer to 2, then ch1/ch3 alternate
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0, 1'b0, 4'b0010, 1'b0));
        tbl.push_back(mk(4'b1010, 4'b1010, 4'b0, 1'b0, 4'b1000, 1'b0));
        tbl.push_back(mk(4'b1010, 4'b1010, 4'b0, 1'b0, 4'b0010, 1'b0));
        tbl.push_back(mk(4'b1010, 4'b1010, 4'b0, 1'b0, 4'b1000, 1'b0));
        tbl.push_back(mk(4'b1010, 4'b1010, 4'b0, 1'b0, 4'b0010, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0, 1'b0, 4'b0000, 1'b0));
        run_tbl();
        check_cnt(0, 0);
        check_cnt(2, 0);

        // Interleaved 1,1,1 on ch0 and ch2
        reset_dut();
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mk(4'b0101, 4'b0101, 4'b0, 1'b0, 4'b0001, r == 2));
            tbl.push_back(mk(4'b0101, 4'b0101, 4'b0, 1'b0, 4'b0100, r == 2));
        end
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0, 1'b0, 4'b0000, 1'b0));
        run_tbl();
        check_cnt(0, 1);
        check_cnt(2, 1);

        // Hit coinciding with flush and counter clear, then the context restarts from S0
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1));
        run_tbl();
        check_cnt(0, 0);
        check_cnt(2, 0);
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0001, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0, 1'b0, 4'b0000, 1'b0));
        run_tbl();
        check_cnt(0, 1);

        // Six hits on ch1 against a 2-bit counter
        for (int r = 0; r < 8; r++)
            tbl.push_back(mk(4'b0010, 4'b0010, 4'b0, 1'b0, 4'b0010, r >= 2));
        run_tbl();
        check_cnt(1, 3);

        // Reset asserted while a transfer is pending
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_bit   = 4'b0010;
        #1;
        chk("pre_reset_ready", 32'(bus.req_ready), 32'b0010);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_det_valid", 32'(bus.det_valid), 32'd0);
        for (int i = 0; i < NUM_CH; i++) check_cnt(i, 0);
        @(posedge clk);
        #1;
        chk("post_edge_det_valid", 32'(bus.det_valid), 32'd0);
        chk("post_edge_det_hit", 32'(bus.det_hit), 32'd0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("idle_det_valid", 32'(bus.det_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_rr_sched.md
Name: seq_det_rr_sched

Overview:
- Round-robin scheduler that time-shares one overlapping "111" Mealy detector engine among NUM_CH independent serial bit streams.
- Holds a 2-bit run-state context and a saturating hit counter per channel.
- Grants one requester per cycle and runs that channel's bit through the shared next-state/output logic.
- Reports one registered result per accepted bit.
- Sits between the serial front-ends and the status/interrupt logic.

Parameters:
- NUM_CH, 4, number of requesting serial channels (2..16).
- CH_W, 2, width of a channel index; must equal clog2(NUM_CH), minimum 1.
- CNT_W, 8, width of each per-channel hit counter.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_CH  per-channel "bit available".
- req_bit  input  NUM_CH  per-channel serial data bit.
- req_ready  output  NUM_CH  one-hot grant; combinational from req_valid and the priority pointer.
- chan_flush  input  NUM_CH  synchronous per-channel context clear.
- clr_cnt  input  1  synchronous clear of all hit counters.
- det_valid  output  1  registered: a bit was processed last cycle.
- det_ch  output  CH_W  channel index of that bit.
- det_hit  output  1  that bit completed a "111" run.
- cnt_sel  input  CH_W  counter readout select.
- cnt_out  output  CNT_W  hit counter of channel cnt_sel; combinational mux.

Behaviour:
- Reset (asynchronous, active-high):
  - all contexts = S0;
  - all counters = 0;
  - priority pointer = 0;
  - det_valid = 0, det_ch = 0, det_hit = 0.
  - req_ready follows req_valid immediately, since it is combinational.
- Arbitration:
  - search starts at the pointer and wraps modulo NUM_CH;
  - the first channel with req_valid=1 gets req_ready=1; at most one bit of req_ready is set;
  - none valid: req_ready = 0 and the pointer holds.
- Transfer: req_valid & req_ready for channel g at a rising edge. After that edge:
  - pointer = (g+1) mod NUM_CH; the wrap from NUM_CH-1 goes to 0;
  - the context of g is updated.
- Contexts of non-granted channels never change, except by chan_flush.
- Context FSM, run of consecutive 1s, overlapping:
  - S0 (0 ones): bit 1 -> S1; bit 0 -> S0.
  - S1 (1 one): bit 1 -> S2; bit 0 -> S0.
  - S2 (>=2 ones): bit 1 -> S2 with hit=1; bit 0 -> S0.
  - hit = (ctx==S2) & bit, evaluated on the pre-update context.
- Result latency is 1 cycle:
  - det_valid = 1, det_ch = g, det_hit = hit in the cycle after the transfer;
  - det_valid = 0 and det_hit = 0 in any cycle following no transfer;
  - det_ch holds its last value when det_valid = 0.
- Counter of g increments on hit and saturates at 2^CNT_W-1; there is no wrap.
- chan_flush[i]: context i = S0 at the edge.
  - If it coincides with a transfer on i, the transfer completes: det_hit uses the pre-flush context, the counter updates, and the context ends at S0. Flush wins for the context.
- clr_cnt: all counters = 0 at the edge.
  - If it coincides with a hit, clear wins and the counter ends at 0.
  - The result is still reported, with det_hit = 1.
- Reset asserted mid-stream:
  - all state is lost immediately;
  - any in-flight result is not reported.
- A requester may drop req_valid without a grant; no stall or penalty results.
- cnt_sel >= NUM_CH: cnt_out = 0.

Decomposition:
- Shared package/header:
  - state encodings S0 = 2'b00, S1 = 2'b01, S2 = 2'b11;
  - the (ctx, bit) -> {next_ctx, hit} function;
  - counter saturation constant.
- One natural sub-module: rr_arbiter (NUM_CH). Inputs: req vector and pointer. Outputs: one-hot grant and encoded index.
- The context array, counters and output registers stay in the top.

Test Plan:
1. Single channel, continuous stream:
   - Stimulus: reset, then ch0 valid only, bits 1,1,1,1,0,1,1,1.
   - Required: det_hit = 0,0,1,1,0,0,0,1 on consecutive cycles; cnt_out(ch0) = 3.
2. Fairness:
   - Stimulus: all 4 channels valid every cycle for 8 cycles.
   - Required: grants ch0,1,2,3,0,1,2,3; det_ch follows one cycle later.
3. Sparse requests:
   - Stimulus: only ch1 and ch3 valid, pointer at 2.
   - Required: grants ch3, ch1, ch3, ch1; ch0/ch2 contexts and counters unchanged.
4. Interleaving isolation:
   - Stimulus: ch0 and ch2 each send 1,1,1, interleaved under round-robin.
   - Required: exactly one hit per channel, on each channel's third bit; cnt(ch0) = cnt(ch2) = 1.
5. Flush and clear collisions:
   - Stimulus: ch0 in S2; bit 1 arrives with chan_flush[0] = 1 and clr_cnt = 1 in the same cycle.
   - Required: det_hit = 1, cnt(ch0) = 0, context S0. A following 1,1 gives no hit; a third 1 gives a hit.
6. Saturation and reset:
   - Stimulus: with CNT_W = 2, drive 6 hits on ch1.
   - Required: cnt stays at 3.
   - Stimulus: assert reset mid-transfer.
   - Required: det_valid = 0 and all counters = 0 immediately.
